// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: 1:4 valid/ready demultiplexer with a 2-entry FIFO per output channel.
module stream_demux_1_4 #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   input  logic [1:0]     in_sel,
   output logic [3:0]     out_valid,
   input  logic [3:0]     out_ready,
   output logic [4*W-1:0] out_data
);
   logic [1:0]   r_occ  [4];
   logic [W-1:0] r_head [4];
   logic [W-1:0] r_tail [4];
   // in_ready looks only at registered occupancy, never at out_ready
   assign in_ready = !rst && (r_occ[in_sel] != 2'd2);
   genvar c;
   generate
      for (c = 0; c < 4; c++) begin : g_ch
         logic w_push, w_pop;
         assign w_push       = in_valid && in_ready && (in_sel == 2'(c));
         assign w_pop        = out_valid[c] && out_ready[c];
         assign out_valid[c] = (r_occ[c] != 2'd0);
         assign out_data[c*W +: W] = r_head[c];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_occ[c]  <= 2'd0;
               r_head[c] <= '0;
               r_tail[c] <= '0;
            end else begin
               if (w_push && (r_occ[c] == 2'd0 || w_pop))
                  r_head[c] <= in_data;
               else if (w_pop && r_occ[c] == 2'd2)
                  r_head[c] <= r_tail[c];
               if (w_push && !w_pop && r_occ[c] == 2'd1)
                  r_tail[c] <= in_data;
               r_occ[c] <= r_occ[c] + 2'(w_push) - 2'(w_pop);
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb_stream_demux_1_4: randomized check of stream_demux_1_4 against per-channel queue model.
module tb_stream_demux_1_4;
   logic        clk = 0;
   logic        rst = 1;
   logic        in_valid = 0;
   logic        in_ready;
   logic [3:0]  in_data = 0;
   logic [1:0]  in_sel = 0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = 0;
   logic [15:0] out_data;
   logic [3:0]  q [4][$];
   logic        last_acc;
   int          checks = 0;
   int          failures = 0;

   stream_demux_1_4 #(.W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("valid%0d", c), 32'(out_valid[c]), 32'(q[c].size() != 0));
         if (q[c].size() != 0)
            chk($sformatf("data%0d", c), 32'(out_data[c*4 +: 4]), 32'(q[c][0]));
      end
   endtask

   // drive one cycle of inputs, advance the model across the edge, then check outputs
   task automatic cycle(input logic v, input logic [3:0] d, input logic [1:0] s, input logic [3:0] r);
      logic acc;
      in_valid = v; in_data = d; in_sel = s; out_ready = r;
      #1 chk("in_ready", 32'(in_ready), 32'(q[s].size() < 2));
      @(posedge clk);
      acc = v && (q[s].size() < 2);
      for (int c = 0; c < 4; c++)
         if (q[c].size() != 0 && r[c]) void'(q[c].pop_front());
      if (acc) q[s].push_back(d);
      last_acc = acc;
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic v; logic [3:0] d; logic [1:0] s; logic [3:0] r;
      int mode;
      in_valid = 1; in_data = 4'h9; in_sel = 2'd1; out_ready = 4'hf;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h0);
      rst = 0;
      #1 chk("rel_ready", 32'(in_ready), 32'h1);
      cycle(0, 0, 0, 4'hf);
      cycle(1, 4'ha, 0, 4'hf);
      cycle(1, 4'hb, 1, 4'hf);
      cycle(1, 4'hc, 2, 4'hf);
      cycle(1, 4'hd, 3, 4'hf);
      cycle(0, 0, 0, 4'hf);
      cycle(1, 4'h7, 2, 4'hb);
      cycle(1, 4'ha, 2, 4'hb);
      cycle(1, 4'h3, 2, 4'hb);
      chk("bp_held", 32'(last_acc), 32'h0);
      cycle(1, 4'h3, 2, 4'hf);
      cycle(1, 4'h3, 2, 4'hf);
      chk("bp_accept", 32'(last_acc), 32'h1);
      repeat (3) cycle(0, 0, 0, 4'hf);
      for (int i = 0; i < 8; i++) cycle(1, 4'(i + 5), 3, 4'hf);
      cycle(0, 0, 0, 4'hf);
      v = 0; d = 0; s = 0; last_acc = 1;
      for (int i = 0; i < 3000; i++) begin
         mode = i / 500;
         if (!(v && !last_acc)) begin
            v = ($urandom_range(0, 3) != 0);
            d = 4'($urandom);
            s = 2'($urandom);
         end
         r = (mode % 3 == 0) ? 4'($urandom) : (mode % 3 == 1) ? 4'hf :
             4'($urandom & $urandom);
         cycle(v, d, s, r);
      end
      for (int c = 0; c < 4; c++) q[c].delete();
      rst = 1; @(negedge clk); rst = 0;
      cycle(1, 4'h1, 0, 4'h0);
      cycle(1, 4'h2, 0, 4'h0);
      cycle(1, 4'h3, 2, 4'h0);
      cycle(1, 4'h4, 2, 4'h0);
      in_valid = 1; in_sel = 2'd1; in_data = 4'he;
      #2 rst = 1;
      #1 chk("mid_valid", 32'(out_valid), 32'h0);
      chk("mid_data", 32'(out_data), 32'h0);
      chk("mid_ready", 32'(in_ready), 32'h0);
      for (int c = 0; c < 4; c++) q[c].delete();
      @(negedge clk);
      chk("mid_noacc", 32'(out_valid), 32'h0);
      rst = 0;
      cycle(0, 0, 0, 4'hf);
      cycle(0, 0, 0, 4'hf);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
